// File: rtl/flags_bank_if.sv
// Flag-bank bus between the ALU/control side (master) and the flag register bank (slave).
// LW must equal $clog2(DEPTH+1) of the connected flags_bank instance.
interface flags_bank_if #(
    parameter int NF = 4,
    parameter int LW = 3
);
    logic [NF-1:0] FlagIn;
    logic [NF-1:0] WrMask;
    logic          Push;
    logic          Pop;
    logic          Clear;
    logic [NF-1:0] Flags;
    logic [LW-1:0] Level;
    logic          Full;
    logic          Empty;
    logic          StackErr;

    modport master (
        output FlagIn, WrMask, Push, Pop, Clear,
        input  Flags, Level, Full, Empty, StackErr
    );

    modport slave (
        input  FlagIn, WrMask, Push, Pop, Clear,
        output Flags, Level, Full, Empty, StackErr
    );
endinterface

// File: rtl/flags_bank.sv
// Masked condition-flag register with a DEPTH-entry save/restore stack.
// Optional macro FLAGS_BYPASS_EN forwards same-cycle masked writes onto Flags.
module flags_bank #(
    parameter int            NF        = 4,
    parameter int            DEPTH     = 4,
    parameter logic [NF-1:0] RESET_VAL = '0
) (
    input logic         Clk,
    input logic         Reset,
    flags_bank_if.slave bus
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NF-1:0] flags_q, flags_d;
    logic [LW-1:0] level_q, level_d;
    logic          err_q, err_d;
    logic [NF-1:0] stack_q [DEPTH];

    logic [NF-1:0] masked;
    logic [IW-1:0] top_idx, wr_idx;
    logic          soft_rst, full, empty;
    logic          do_push, do_pop, do_swap, stack_err;

    assign soft_rst = Reset | bus.Clear;
    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign wr_idx   = IW'(level_q);
    assign top_idx  = IW'(level_q - LW'(1));
    assign masked   = (flags_q & ~bus.WrMask) | (bus.FlagIn & bus.WrMask);

    // Failed stack ops fall through to a plain masked write
    assign do_push   = bus.Push & ~bus.Pop & ~full;
    assign do_pop    = bus.Pop & ~bus.Push & ~empty;
    assign do_swap   = bus.Push & bus.Pop & ~empty;
    assign stack_err = (bus.Push & ~bus.Pop & full) | (bus.Pop & empty);

    always_comb begin
        flags_d = masked;
        level_d = level_q;
        err_d   = err_q | stack_err;
        if (do_pop || do_swap) begin
            flags_d = stack_q[top_idx];
        end
        if (do_push) begin
            level_d = level_q + LW'(1);
        end else if (do_pop) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (soft_rst) begin
            flags_q <= RESET_VAL;
            level_q <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            level_q <= level_d;
            err_q   <= err_d;
        end
    end

    // Stack entries hold no reset value; they are only read below Level
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stack
            always_ff @(posedge Clk) begin
                if (!soft_rst && ((do_push && wr_idx == IW'(gi)) ||
                                  (do_swap && top_idx == IW'(gi)))) begin
                    stack_q[gi] <= flags_q;
                end
            end
        end
    endgenerate

`ifdef FLAGS_BYPASS_EN
    assign bus.Flags = (soft_rst | do_pop | do_swap) ? flags_q : masked;
`else
    assign bus.Flags = flags_q;
`endif
    assign bus.Level    = level_q;
    assign bus.Full     = full;
    assign bus.Empty    = empty;
    assign bus.StackErr = err_q;
endmodule

// File: tb/tb_flags_bank.sv
// Self-checking bench for flags_bank: directed vector table, LIFO sequence, random vs. queue model.
module tb_flags_bank;
    localparam int NF    = 4;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    flags_bank_if #(.NF(NF), .LW(LW)) bus ();

    flags_bank #(.NF(NF), .DEPTH(DEPTH), .RESET_VAL(4'b0000)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    typedef struct {
        logic          rst;
        logic          clr;
        logic          push;
        logic          pop;
        logic [NF-1:0] fin;
        logic [NF-1:0] msk;
        logic [NF-1:0] e_flags;
        logic [LW-1:0] e_level;
        logic          e_full;
        logic          e_empty;
        logic          e_err;
    } vec_t;

    vec_t vecs [28];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference state for the random phase
    logic [NF-1:0] m_flags;
    logic [NF-1:0] m_stack [$];
    logic          m_err;

    task automatic drive(input logic r, input logic c, input logic pu, input logic po,
                         input logic [NF-1:0] fi, input logic [NF-1:0] mk);
        rst        = r;
        bus.Clear  = c;
        bus.Push   = pu;
        bus.Pop    = po;
        bus.FlagIn = fi;
        bus.WrMask = mk;
    endtask

    task automatic check(input string name, input logic [NF+LW+2:0] got,
                         input logic [NF+LW+2:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("%s ok flags/level/full/empty/err=%b", name, got);
        end else begin
            $display("FAIL %s got=%b expected=%b", name, got, exp);
        end
    endtask

    function automatic logic [NF+LW+2:0] dut_state();
        return {bus.Flags, bus.Level, bus.Full, bus.Empty, bus.StackErr};
    endfunction

    function automatic vec_t mk(input logic r, input logic c, input logic pu, input logic po,
                                input logic [NF-1:0] fi, input logic [NF-1:0] ms,
                                input logic [NF-1:0] ef, input logic [LW-1:0] el,
                                input logic eu, input logic ee, input logic er);
        vec_t v;
        v.rst = r; v.clr = c; v.push = pu; v.pop = po; v.fin = fi; v.msk = ms;
        v.e_flags = ef; v.e_level = el; v.e_full = eu; v.e_empty = ee; v.e_err = er;
        return v;
    endfunction

    initial begin
        //              rst clr psh pop fin      msk      flags    lvl full emp err
        vecs[0]  = mk(1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 0);
        vecs[1]  = mk(0, 0, 0, 0, 4'b1111, 4'b0101, 4'b0101, 0, 0, 1, 0);
        vecs[2]  = mk(0, 0, 0, 0, 4'b0011, 4'b1111, 4'b0011, 0, 0, 1, 0);
        vecs[3]  = mk(0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0011, 1, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0, 4'b1100, 4'b1111, 4'b1100, 1, 0, 0, 0);
        vecs[5]  = mk(0, 0, 0, 1, 4'b1111, 4'b1111, 4'b0011, 0, 0, 1, 0);
        vecs[6]  = mk(0, 0, 1, 0, 4'b0001, 4'b1111, 4'b0001, 1, 0, 0, 0);
        vecs[7]  = mk(0, 0, 1, 0, 4'b0010, 4'b1111, 4'b0010, 2, 0, 0, 0);
        vecs[8]  = mk(0, 0, 1, 0, 4'b0100, 4'b1111, 4'b0100, 3, 0, 0, 0);
        vecs[9]  = mk(0, 0, 1, 0, 4'b1000, 4'b1111, 4'b1000, 4, 1, 0, 0);
        vecs[10] = mk(0, 0, 1, 0, 4'b0000, 4'b0000, 4'b1000, 4, 1, 0, 1);
        vecs[11] = mk(0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0100, 3, 0, 0, 1);
        vecs[12] = mk(0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0010, 2, 0, 0, 1);
        vecs[13] = mk(0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0001, 1, 0, 0, 1);
        vecs[14] = mk(0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0011, 0, 0, 1, 1);
        vecs[15] = mk(0, 0, 0, 1, 4'b1010, 4'b1111, 4'b1010, 0, 0, 1, 1);
        vecs[16] = mk(0, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 0);
        vecs[17] = mk(0, 0, 0, 0, 4'b1000, 4'b1111, 4'b1000, 0, 0, 1, 0);
        vecs[18] = mk(0, 0, 1, 0, 4'b0001, 4'b1111, 4'b0001, 1, 0, 0, 0);
        vecs[19] = mk(0, 0, 1, 1, 4'b0110, 4'b1111, 4'b1000, 1, 0, 0, 0);
        vecs[20] = mk(0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0001, 0, 0, 1, 0);
        vecs[21] = mk(0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0001, 0, 0, 1, 1);
        vecs[22] = mk(0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0001, 1, 0, 0, 1);
        vecs[23] = mk(0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0001, 2, 0, 0, 1);
        vecs[24] = mk(0, 1, 1, 0, 4'b1111, 4'b1111, 4'b0000, 0, 0, 1, 0);
        vecs[25] = mk(0, 0, 1, 0, 4'b1111, 4'b1111, 4'b1111, 1, 0, 0, 0);
        vecs[26] = mk(1, 0, 1, 1, 4'b1111, 4'b1111, 4'b0000, 0, 0, 1, 0);
        vecs[27] = mk(0, 0, 1, 1, 4'b0101, 4'b0011, 4'b0001, 0, 0, 1, 1);

        for (int i = 0; i < 28; i++) begin
            drive(vecs[i].rst, vecs[i].clr, vecs[i].push, vecs[i].pop, vecs[i].fin, vecs[i].msk);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), dut_state(),
                  {vecs[i].e_flags, vecs[i].e_level, vecs[i].e_full, vecs[i].e_empty, vecs[i].e_err});
        end

        // LIFO order: load distinct values, push them all, then pop back in reverse
        drive(1, 0, 0, 0, 4'b0000, 4'b0000);
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, 1, 0, 4'(i + 9), 4'b1111);
            @(posedge clk); #1;
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            drive(0, 0, 0, 1, 4'b0000, 4'b0000);
            @(posedge clk); #1;
            // entry i holds the flags in place before push i (0 for the first push)
            check($sformatf("lifo%0d", i), dut_state(),
                  {(i == 0) ? 4'b0000 : 4'(i + 8), 3'(i), 1'b0, (i == 0), 1'b0});
        end

        // Random phase against a queue-based model
        for (int t = 0; t < 300; t++) begin
            logic r, c, pu, po;
            logic [NF-1:0] fi, ms, mw;
            r  = (t == 0) || ($urandom_range(0, 63) == 0);
            c  = ($urandom_range(0, 31) == 0);
            pu = ($urandom_range(0, 99) < 45);
            po = ($urandom_range(0, 99) < 40);
            fi = 4'($urandom);
            ms = 4'($urandom);
            drive(r, c, pu, po, fi, ms);
            mw = (m_flags & ~ms) | (fi & ms);
            if (r || c) begin
                m_flags = 4'b0000;
                m_stack.delete();
                m_err = 1'b0;
            end else if (pu && po) begin
                if (m_stack.size() == 0) begin
                    m_err = 1'b1;
                    m_flags = mw;
                end else begin
                    logic [NF-1:0] tmp;
                    tmp = m_stack[m_stack.size() - 1];
                    m_stack[m_stack.size() - 1] = m_flags;
                    m_flags = tmp;
                end
            end else if (pu) begin
                if (m_stack.size() == DEPTH) m_err = 1'b1;
                else m_stack.push_back(m_flags);
                m_flags = mw;
            end else if (po) begin
                if (m_stack.size() == 0) begin
                    m_err = 1'b1;
                    m_flags = mw;
                end else begin
                    m_flags = m_stack.pop_back();
                end
            end else begin
                m_flags = mw;
            end
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d r%0b c%0b pu%0b po%0b fi%b m%b", t, r, c, pu, po, fi, ms),
                  dut_state(),
                  {m_flags, 3'(m_stack.size()), (m_stack.size() == DEPTH),
                   (m_stack.size() == 0), m_err});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
